// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and constants for the fetch stage and instruction field decode (TRAP state only with FETCH_MISALIGN_CHECK_EN)
package fetch_pkg;
  localparam int INSTR_W = 32;
  localparam int OPC_LSB = 0;
  localparam int OPC_MSB = 6;
  localparam int RD_LSB = 7;
  localparam int RD_MSB = 11;
  localparam int F3_LSB = 12;
  localparam int F3_MSB = 14;
  localparam int RS1_LSB = 15;
  localparam int RS1_MSB = 19;
  localparam int RS2_LSB = 20;
  localparam int RS2_MSB = 24;
  localparam int F7_5_BIT = 30;
  localparam logic [6:0] OP_R = 7'h33;
  localparam logic [6:0] OP_I = 7'h13;
  localparam logic [6:0] OP_LOAD = 7'h03;
  localparam logic [6:0] OP_STORE = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63;
  localparam logic [6:0] OP_JAL = 7'h6f;
`ifdef FETCH_MISALIGN_CHECK_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, TRAP} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif
endpackage

// File: rtl/instr_fields.sv
// instr_fields: combinational split of an instruction word into its register and opcode fields
module instr_fields
  import fetch_pkg::*;
(
  input  logic [INSTR_W-1:0] instr,
  output logic [6:0]         opcode,
  output logic [2:0]         f3,
  output logic               f7_5,
  output logic [4:0]         rd,
  output logic [4:0]         rs1,
  output logic [4:0]         rs2
);
  assign opcode = instr[OPC_MSB:OPC_LSB];
  assign f3 = instr[F3_MSB:F3_LSB];
  assign f7_5 = instr[F7_5_BIT];
  assign rd = instr[RD_MSB:RD_LSB];
  assign rs1 = instr[RS1_MSB:RS1_LSB];
  assign rs2 = instr[RS2_MSB:RS2_LSB];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and single-outstanding instruction fetch with held, decoded IR (misalignment trap with FETCH_MISALIGN_CHECK_EN)
module fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req_s,
  output logic [31:0]        imem_addr_s,
  input  logic               imem_valid_s,
  input  logic [INSTR_W-1:0] imem_rdata_s,
  output logic               id_valid_s,
  input  logic               id_ready_s,
  input  logic               pcSrc_s,
  input  logic [31:0]        pcTarget_s,
  output logic [INSTR_W-1:0] instr_s,
  output logic [6:0]         opcode_s,
  output logic [2:0]         f3_s,
  output logic               f7_5_s,
  output logic [4:0]         rd_s,
  output logic [4:0]         rs1_s,
  output logic [4:0]         rs2_s,
  output logic [31:0]        pc_s,
`ifdef FETCH_MISALIGN_CHECK_EN
  output logic               misaligned_s,
`endif
  output logic [31:0]        pcPlus4_s
);
  state_t state, state_nxt;
  logic [31:0] pc_sel, pc_nxt;
  logic retire, bad_pc;
  assign retire = state == HOLD && id_ready_s;
  assign pc_sel = pcSrc_s ? pcTarget_s : pcPlus4_s;
`ifdef FETCH_MISALIGN_CHECK_EN
  assign pc_nxt = pc_sel;
  assign bad_pc = |pc_sel[1:0];
  assign misaligned_s = state == TRAP;
`else
  assign pc_nxt = {pc_sel[31:2], 2'b00};
  assign bad_pc = 1'b0;
`endif
  assign pcPlus4_s = pc_s + 32'd4;
  assign imem_req_s = state == FETCH;
  assign imem_addr_s = pc_s;
  assign id_valid_s = state == HOLD;
  // state register; IDLE is only reachable through reset
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  // next state: hold the request until the response, hold the IR until retire
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = FETCH;
      FETCH: state_nxt = imem_valid_s ? HOLD : FETCH;
      HOLD: state_nxt = !id_ready_s ? HOLD : bad_pc ? state_t'(2'd3) : FETCH;
      default: state_nxt = state;
    endcase
  end
  // datapath: capture the response in FETCH, advance the PC on retire
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      pc_s <= RESET_PC;
      instr_s <= '0;
    end else begin
      if (state == FETCH && imem_valid_s) instr_s <= imem_rdata_s;
      if (retire) pc_s <= pc_nxt;
    end
  instr_fields u_fields (
    .instr  (instr_s),
    .opcode (opcode_s),
    .f3     (f3_s),
    .f7_5   (f7_5_s),
    .rd     (rd_s),
    .rs1    (rs1_s),
    .rs2    (rs2_s)
  );
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized fetch/handshake traffic checked against a transaction-level PC/IR model
module tb_fetch_unit;
  logic clk = 1'b0;
  logic rst_n;
  logic imem_req_s, imem_valid_s, id_valid_s, id_ready_s, pcSrc_s, f7_5_s;
  logic [31:0] imem_addr_s, imem_rdata_s, pcTarget_s, instr_s, pc_s, pcPlus4_s;
  logic [6:0] opcode_s;
  logic [2:0] f3_s;
  logic [4:0] rd_s, rs1_s, rs2_s;
`ifdef FETCH_MISALIGN_CHECK_EN
  logic misaligned_s;
`endif
  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_pc, exp_ir;

  always #5 clk = ~clk;

  fetch_unit #(.RESET_PC(32'h0)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .imem_req_s   (imem_req_s),
    .imem_addr_s  (imem_addr_s),
    .imem_valid_s (imem_valid_s),
    .imem_rdata_s (imem_rdata_s),
    .id_valid_s   (id_valid_s),
    .id_ready_s   (id_ready_s),
    .pcSrc_s      (pcSrc_s),
    .pcTarget_s   (pcTarget_s),
    .instr_s      (instr_s),
    .opcode_s     (opcode_s),
    .f3_s         (f3_s),
    .f7_5_s       (f7_5_s),
    .rd_s         (rd_s),
    .rs1_s        (rs1_s),
    .rs2_s        (rs2_s),
    .pc_s         (pc_s),
`ifdef FETCH_MISALIGN_CHECK_EN
    .misaligned_s (misaligned_s),
`endif
    .pcPlus4_s    (pcPlus4_s)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_hold();
    check("id_valid", {31'd0, id_valid_s}, 32'd1);
    check("req_hold", {31'd0, imem_req_s}, 32'd0);
    check("instr", instr_s, exp_ir);
    check("pc", pc_s, exp_pc);
    check("pc_plus4", pcPlus4_s, exp_pc + 32'd4);
    check("opcode", {25'd0, opcode_s}, {25'd0, exp_ir[6:0]});
    check("f3", {29'd0, f3_s}, {29'd0, exp_ir[14:12]});
    check("f7_5", {31'd0, f7_5_s}, {31'd0, exp_ir[30]});
    check("rd", {27'd0, rd_s}, {27'd0, exp_ir[11:7]});
    check("rs1", {27'd0, rs1_s}, {27'd0, exp_ir[19:15]});
    check("rs2", {27'd0, rs2_s}, {27'd0, exp_ir[24:20]});
  endtask

  // called at a negedge with the DUT expected in FETCH; memory answers after lat wait cycles
  task automatic do_fetch(input int lat, input logic [31:0] word);
    for (int i = 0; i <= lat; i++) begin
      check("req", {31'd0, imem_req_s}, 32'd1);
      check("addr", imem_addr_s, exp_pc);
      check("id_valid_fetch", {31'd0, id_valid_s}, 32'd0);
      imem_valid_s = (i == lat);
      imem_rdata_s = (i == lat) ? word : $urandom;
      @(negedge clk);
    end
    imem_valid_s = 1'b0;
    imem_rdata_s = $urandom;
    exp_ir = word;
    check_hold();
  endtask

  // downstream stalls; stray responses and branch inputs must be ignored
  task automatic stall(input int n);
    for (int i = 0; i < n; i++) begin
      id_ready_s = 1'b0;
      imem_valid_s = 1'($urandom);
      imem_rdata_s = $urandom;
      pcSrc_s = 1'($urandom);
      pcTarget_s = $urandom;
      @(negedge clk);
      check_hold();
    end
    imem_valid_s = 1'b0;
  endtask

  task automatic handshake(input logic src, input logic [31:0] tgt);
    id_ready_s = 1'b1;
    pcSrc_s = src;
    pcTarget_s = tgt;
    @(negedge clk);
    id_ready_s = 1'b0;
    pcSrc_s = 1'($urandom);
    pcTarget_s = $urandom;
    exp_pc = src ? tgt : exp_pc + 32'd4;
    exp_pc[1:0] = 2'b00;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc = 32'h0;
  endtask

  initial begin
    rst_n = 1'b0;
    imem_valid_s = 1'b0;
    imem_rdata_s = 32'h0;
    id_ready_s = 1'b0;
    pcSrc_s = 1'b0;
    pcTarget_s = 32'h0;
    @(negedge clk);
    @(negedge clk);
    check("rst_pc", pc_s, 32'h0);
    check("rst_instr", instr_s, 32'h0);
    check("rst_req", {31'd0, imem_req_s}, 32'd0);
    check("rst_id_valid", {31'd0, id_valid_s}, 32'd0);
    check("rst_pc_plus4", pcPlus4_s, 32'h4);
    check("rst_opcode", {25'd0, opcode_s}, 32'd0);
`ifdef FETCH_MISALIGN_CHECK_EN
    check("rst_misaligned", {31'd0, misaligned_s}, 32'd0);
`endif
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc = 32'h0;
    do_fetch(0, 32'h002081B3);
    check("tp_opcode", {25'd0, opcode_s}, 32'h33);
    check("tp_rd", {27'd0, rd_s}, 32'd3);
    check("tp_rs1", {27'd0, rs1_s}, 32'd1);
    check("tp_rs2", {27'd0, rs2_s}, 32'd2);
    handshake(1'b1, 32'h40);
    do_fetch(3, $urandom);
    stall(5);
    handshake(1'b0, 32'h0);
    check("addr_44", imem_addr_s, 32'h44);
    do_fetch(1, $urandom);
    handshake(1'b1, 32'h10);
    do_fetch(0, $urandom);
    handshake(1'b0, 32'h0);
    check("addr_14", imem_addr_s, 32'h14);
    do_fetch(2, $urandom);
    handshake(1'b1, 32'hFFFF_FFFC);
    do_fetch(0, $urandom);
    handshake(1'b0, 32'h0);
    check("addr_wrap", imem_addr_s, 32'h0);
    do_fetch(0, $urandom);
    for (int k = 0; k < 30; k++) begin
      stall($urandom_range(0, 3));
      handshake(1'($urandom), $urandom & 32'hFFFF_FFFC);
      do_fetch($urandom_range(0, 4), $urandom);
    end
`ifdef FETCH_MISALIGN_CHECK_EN
    id_ready_s = 1'b1;
    pcSrc_s = 1'b1;
    pcTarget_s = 32'h42;
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      id_ready_s = 1'($urandom);
      imem_valid_s = 1'($urandom);
      pcSrc_s = 1'($urandom);
      pcTarget_s = $urandom;
      check("trap_misaligned", {31'd0, misaligned_s}, 32'd1);
      check("trap_req", {31'd0, imem_req_s}, 32'd0);
      check("trap_id_valid", {31'd0, id_valid_s}, 32'd0);
      check("trap_pc", pc_s, 32'h42);
      @(negedge clk);
    end
    id_ready_s = 1'b0;
    imem_valid_s = 1'b0;
    do_reset();
    check("post_trap_misaligned", {31'd0, misaligned_s}, 32'd0);
    do_fetch(1, $urandom);
`else
    handshake(1'b1, 32'h42);
    check("addr_forced_align", imem_addr_s, 32'h40);
    do_fetch(1, $urandom);
`endif
    handshake(1'b1, 32'h100);
    check("req_pre_reset", {31'd0, imem_req_s}, 32'd1);
    rst_n = 1'b0;
    #1;
    check("midfetch_req", {31'd0, imem_req_s}, 32'd0);
    check("midfetch_pc", pc_s, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    exp_pc = 32'h0;
    do_fetch(2, $urandom);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
